// File: rtl/spi_reg_reader.sv
// SPI mode-0 read engine for the nRF24L01: one command byte out, then 1..32 data bytes in.
// STATUS and each data byte are presented with one-cycle strobes; csn low for SETUP+(N+1)*16*CLK_DIV+HOLD cycles.
module spi_reg_reader #(
    parameter int CLK_DIV   = 2,
    parameter int CSN_SETUP = 1,
    parameter int CSN_HOLD  = 1
) (
    input  logic       clk_10,
    input  logic       rst,
    input  logic       start_rd,
    input  logic [7:0] cmd_byte,
    input  logic [5:0] rd_len,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       csn,
    output logic [7:0] status_out,
    output logic       status_valid,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done_rd
);
    localparam int CW = 16;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic [2:0]    r_bit;
    logic [5:0]    r_byte;
    logic [5:0]    r_len;
    logic [7:0]    r_cmd;
    logic [7:0]    r_shift;

    logic [CW-1:0] w_limit;
    logic          w_cnt_end;
    logic          w_accept;
    logic          w_rise;
    logic          w_fall;
    logic          w_byte_end;
    logic          w_last_byte;
    logic          w_hold_end;
    logic [5:0]    w_len_clamped;

    always_ff @(posedge clk_10 or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_rd)    w_state_nxt = S_SETUP;
            S_SETUP: if (w_cnt_end)   w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_byte) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_cnt_end)   w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // One shared counter times the setup gap, each SCK half-period and the hold gap.
    always_comb begin
        w_limit = '0;
        case (r_state)
            S_SETUP: w_limit = CW'(CSN_SETUP - 1);
            S_SHIFT: w_limit = CW'(CLK_DIV - 1);
            S_HOLD:  w_limit = CW'(CSN_HOLD - 1);
            default: w_limit = '0;
        endcase
        w_cnt_end   = (r_cnt == w_limit);
        w_accept    = (r_state == S_IDLE) && start_rd;
        w_rise      = (r_state == S_SHIFT) && !r_phase && w_cnt_end;
        w_fall      = (r_state == S_SHIFT) && r_phase && w_cnt_end;
        w_byte_end  = w_fall && (r_bit == 3'd7);
        w_last_byte = w_byte_end && (r_byte == r_len);
        w_hold_end  = (r_state == S_HOLD) && w_cnt_end;
        if (rd_len == 6'd0)       w_len_clamped = 6'd1;
        else if (rd_len > 6'd32)  w_len_clamped = 6'd32;
        else                      w_len_clamped = rd_len;
    end

    always_ff @(posedge clk_10 or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_phase      <= 1'b0;
            r_bit        <= '0;
            r_byte       <= '0;
            r_len        <= '0;
            r_cmd        <= '0;
            r_shift      <= '0;
            sck          <= 1'b0;
            mosi         <= 1'b0;
            csn          <= 1'b1;
            status_out   <= '0;
            status_valid <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            busy         <= 1'b0;
            done_rd      <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            rx_valid     <= 1'b0;
            done_rd      <= 1'b0;

            if (w_cnt_end) r_cnt <= '0;
            else           r_cnt <= r_cnt + CW'(1);

            if (w_accept) begin
                r_cmd   <= cmd_byte;
                r_len   <= w_len_clamped;
                r_byte  <= '0;
                r_bit   <= '0;
                r_phase <= 1'b0;
                csn     <= 1'b0;
                busy    <= 1'b1;
                mosi    <= cmd_byte[7];
            end

            if (w_rise) begin
                sck     <= 1'b1;
                r_phase <= 1'b1;
                r_shift <= {r_shift[6:0], miso};
            end

            // Ones are shifted in behind the command so data bytes send 0xFF dummies.
            if (w_fall) begin
                sck     <= 1'b0;
                r_phase <= 1'b0;
                r_bit   <= r_bit + 3'd1;
                r_cmd   <= {r_cmd[6:0], 1'b1};
                mosi    <= w_last_byte ? 1'b0 : r_cmd[6];
            end

            if (w_byte_end) begin
                r_byte <= r_byte + 6'd1;
                if (r_byte == 6'd0) begin
                    status_out   <= r_shift;
                    status_valid <= 1'b1;
                end else begin
                    rx_data  <= r_shift;
                    rx_valid <= 1'b1;
                end
            end

            if (w_hold_end) begin
                csn     <= 1'b1;
                busy    <= 1'b0;
                done_rd <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_reader.sv
// Bench for spi_reg_reader: two instances (CLK_DIV=2/1/1 and CLK_DIV=1,SETUP=3,HOLD=2) driven by a mode-0 slave model.
module tb_spi_reg_reader;
    logic       clk_10 = 1'b0;
    logic       rst    = 1'b1;
    logic       start_rd     [2];
    logic [7:0] cmd_byte     [2];
    logic [5:0] rd_len       [2];
    logic       miso         [2];
    logic       sck          [2];
    logic       mosi         [2];
    logic       csn          [2];
    logic [7:0] status_out   [2];
    logic       status_valid [2];
    logic [7:0] rx_data      [2];
    logic       rx_valid     [2];
    logic       busy         [2];
    logic       done_rd      [2];

    logic [7:0] slv [33];
    int n_err = 0;
    int n_chk = 0;

    always #50 clk_10 = ~clk_10;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_reg_reader #(
            .CLK_DIV  (g == 0 ? 2 : 1),
            .CSN_SETUP(g == 0 ? 1 : 3),
            .CSN_HOLD (g == 0 ? 1 : 2)
        ) u_dut (
            .clk_10      (clk_10),
            .rst         (rst),
            .start_rd    (start_rd[g]),
            .cmd_byte    (cmd_byte[g]),
            .rd_len      (rd_len[g]),
            .miso        (miso[g]),
            .sck         (sck[g]),
            .mosi        (mosi[g]),
            .csn         (csn[g]),
            .status_out  (status_out[g]),
            .status_valid(status_valid[g]),
            .rx_data     (rx_data[g]),
            .rx_valid    (rx_valid[g]),
            .busy        (busy[g]),
            .done_rd     (done_rd[g])
        );
    end

    function automatic int p_div(input int d);  return (d == 0) ? 2 : 1; endfunction
    function automatic int p_set(input int d);  return (d == 0) ? 1 : 3; endfunction
    function automatic int p_hold(input int d); return (d == 0) ? 1 : 2; endfunction

    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > 32) return 32;
        return l;
    endfunction

    function automatic int model_low(input int d, input int n);
        return p_set(d) + (n + 1) * 16 * p_div(d) + p_hold(d);
    endfunction

    // Bit i of the MOSI stream: command MSB first, then 0xFF dummies.
    function automatic logic exp_bit(input logic [7:0] c, input int i);
        if (i < 8) return c[7 - i];
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fill_slave(input int nfix, input logic [47:0] fix);
        for (int i = 0; i < 33; i++) begin
            if (i < nfix) slv[i] = fix[47 - 8 * i -: 8];
            else          slv[i] = 8'($urandom);
        end
    endtask

    // Runs one transaction on instance d from a negedge; returns on the negedge where csn is seen high.
    task automatic run_txn(input int d, input logic [7:0] cmd, input logic [5:0] len,
                           input int exp_n, input int exp_low, input bit pre_started,
                           input bit keep_start, input logic [7:0] nxt_cmd,
                           input logic [5:0] nxt_len, input bit poke, input string nm);
        int low, t, k, rises, first_rise, last_fall, prev_rise, gap_bad, mosi_bad;
        int st_cnt, rx_cnt, prev_rx, rx_gap_bad, done_early, busy_bad;
        logic [7:0] st_val;
        logic [7:0] rx_seen [32];
        logic prev_sck;
        low = 0; t = 1; k = 0; rises = 0; first_rise = -1; last_fall = 0; prev_rise = 0;
        gap_bad = 0; mosi_bad = 0; st_cnt = 0; rx_cnt = 0; prev_rx = 0; rx_gap_bad = 0;
        done_early = 0; busy_bad = 0; st_val = '0; prev_sck = 1'b0;
        if (!pre_started) begin
            cmd_byte[d] = cmd;
            rd_len[d]   = len;
            start_rd[d] = 1'b1;
        end
        @(negedge clk_10);
        chk({nm, "_csn_fall"}, csn[d], 0);
        if (!keep_start) start_rd[d] = 1'b0;
        cmd_byte[d] = nxt_cmd;
        rd_len[d]   = nxt_len;
        miso[d]     = slv[0][7];
        while (csn[d] == 1'b0 && low < 1200) begin
            low++;
            if (busy[d] !== 1'b1) busy_bad++;
            if (done_rd[d]) done_early++;
            if (!prev_sck && sck[d]) begin
                if (rises == 0) first_rise = t - 1;
                else if (t - prev_rise != 2 * p_div(d)) gap_bad++;
                prev_rise = t;
                if (rises < 8 * (exp_n + 1) && mosi[d] !== exp_bit(cmd, rises)) mosi_bad++;
                rises++;
            end
            if (prev_sck && !sck[d]) begin
                last_fall = t;
                k++;
                miso[d] = (k < 8 * 33) ? slv[k / 8][7 - (k % 8)] : 1'b0;
            end
            if (status_valid[d]) begin
                st_cnt++;
                st_val = status_out[d];
            end
            if (rx_valid[d]) begin
                if (rx_cnt < 32) rx_seen[rx_cnt] = rx_data[d];
                if (rx_cnt > 0 && t - prev_rx != 16 * p_div(d)) rx_gap_bad++;
                prev_rx = t;
                rx_cnt++;
            end
            if (poke && low == 40) start_rd[d] = 1'b1;
            if (poke && low == 41) start_rd[d] = 1'b0;
            prev_sck = sck[d];
            @(negedge clk_10);
            t++;
        end
        chk({nm, "_csn_low"}, low, exp_low);
        chk({nm, "_done_end"}, done_rd[d], 1);
        chk({nm, "_busy_end"}, busy[d], 0);
        chk({nm, "_sck_end"}, sck[d], 0);
        chk({nm, "_mosi_end"}, mosi[d], 0);
        chk({nm, "_done_early"}, done_early, 0);
        chk({nm, "_busy_low"}, busy_bad, 0);
        chk({nm, "_rises"}, rises, 8 * (exp_n + 1));
        chk({nm, "_first_rise"}, first_rise, p_set(d) + p_div(d));
        chk({nm, "_sck_period"}, gap_bad, 0);
        chk({nm, "_hold"}, t - last_fall, p_hold(d));
        chk({nm, "_mosi_bits"}, mosi_bad, 0);
        chk({nm, "_status_cnt"}, st_cnt, 1);
        chk({nm, "_status_val"}, st_val, slv[0]);
        chk({nm, "_rx_cnt"}, rx_cnt, exp_n);
        chk({nm, "_rx_gap"}, rx_gap_bad, 0);
        for (int i = 0; i < exp_n && i < rx_cnt; i++)
            chk($sformatf("%s_rx%0d", nm, i), rx_seen[i], slv[i + 1]);
    endtask

    typedef struct {
        int          d;
        logic [7:0]  cmd;
        logic [5:0]  len;
        int          nfix;
        logic [47:0] fix;
        bit          poke;
        int          exp_n;
        int          exp_low;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int d, n, len, k, rises, t, viol;
        logic [7:0] cmd;
        logic prev;

        vecs[0] = '{0, 8'h07, 6'd1,  2, 48'h0E40_0000_0000, 1'b0, 1,  66};
        vecs[1] = '{0, 8'h61, 6'd5,  6, 48'h0EA5_5A01_80FF, 1'b0, 5,  194};
        vecs[2] = '{0, 8'h03, 6'd0,  0, 48'h0,              1'b0, 1,  66};
        vecs[3] = '{0, 8'h61, 6'd40, 0, 48'h0,              1'b0, 32, 1058};
        vecs[4] = '{0, 8'h05, 6'd2,  0, 48'h0,              1'b1, 2,  98};
        vecs[5] = '{1, 8'h07, 6'd1,  2, 48'h0E40_0000_0000, 1'b0, 1,  37};
        vecs[6] = '{1, 8'h61, 6'd3,  0, 48'h0,              1'b0, 3,  69};

        for (int i = 0; i < 2; i++) begin
            start_rd[i] = 1'b0; cmd_byte[i] = '0; rd_len[i] = '0; miso[i] = 1'b0;
        end
        for (int i = 0; i < 33; i++) slv[i] = '0;

        @(negedge clk_10);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d_csn", i), csn[i], 1);
            chk($sformatf("rst%0d_sck", i), sck[i], 0);
            chk($sformatf("rst%0d_mosi", i), mosi[i], 0);
            chk($sformatf("rst%0d_busy", i), busy[i], 0);
            chk($sformatf("rst%0d_status", i), status_out[i], 0);
            chk($sformatf("rst%0d_rxdata", i), rx_data[i], 0);
            chk($sformatf("rst%0d_strobes", i), {status_valid[i], rx_valid[i], done_rd[i]}, 0);
        end
        @(negedge clk_10);
        rst = 1'b0;
        @(negedge clk_10);

        for (int v = 0; v < 7; v++) begin
            fill_slave(vecs[v].nfix, vecs[v].fix);
            run_txn(vecs[v].d, vecs[v].cmd, vecs[v].len, vecs[v].exp_n, vecs[v].exp_low,
                    1'b0, 1'b0, 8'($urandom), 6'($urandom), vecs[v].poke, $sformatf("vec%0d", v));
            repeat (2) @(negedge clk_10);
        end

        for (int r = 0; r < 6; r++) begin
            d   = int'($urandom_range(0, 1));
            cmd = 8'($urandom);
            len = int'($urandom_range(0, 63));
            n   = clamp_len(len);
            fill_slave(0, 48'h0);
            run_txn(d, cmd, 6'(len), n, model_low(d, n), 1'b0, 1'b0,
                    8'($urandom), 6'($urandom), 1'b0, $sformatf("rnd%0d", r));
            repeat (int'($urandom_range(0, 3))) @(negedge clk_10);
        end

        // start_rd held high: the second transaction must follow done_rd after one csn-high cycle.
        fill_slave(0, 48'h0);
        run_txn(1, 8'h11, 6'd2, 2, model_low(1, 2), 1'b0, 1'b1, 8'h22, 6'd1, 1'b0, "held_a");
        fill_slave(0, 48'h0);
        run_txn(1, 8'h22, 6'd1, 1, model_low(1, 1), 1'b1, 1'b0,
                8'($urandom), 6'($urandom), 1'b0, "held_b");
        repeat (2) @(negedge clk_10);

        // Asynchronous reset during byte 1, bit 3.
        fill_slave(0, 48'h0);
        cmd_byte[0] = 8'h61; rd_len[0] = 6'd4; start_rd[0] = 1'b1;
        @(negedge clk_10);
        start_rd[0] = 1'b0;
        miso[0] = slv[0][7];
        k = 0; rises = 0; t = 0; prev = 1'b0;
        while (rises < 12 && t < 500) begin
            if (!prev && sck[0]) rises++;
            if (prev && !sck[0]) begin
                k++;
                miso[0] = slv[k / 8][7 - (k % 8)];
            end
            prev = sck[0];
            if (rises < 12) begin
                @(negedge clk_10);
                t++;
            end
        end
        chk("rstmid_reach", rises, 12);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_csn", csn[0], 1);
        chk("rstmid_sck", sck[0], 0);
        chk("rstmid_busy", busy[0], 0);
        @(posedge clk_10);
        @(negedge clk_10);
        rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_10);
            if (status_valid[0] || rx_valid[0] || done_rd[0] || !csn[0]) viol++;
        end
        chk("rstmid_quiet", viol, 0);
        fill_slave(2, 48'h0E40_0000_0000);
        run_txn(0, 8'h07, 6'd1, 1, 66, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
